atmega_pcint: RTL and testbench

- Pin-change interrupt controller for one 8-bit port; sits directly downstream of the PIO block.
- Samples the port's pad levels (the PIO `io` net) and sets a change flag on any enabled pin toggle.
- Raises an interrupt request to the core's interrupt vector logic.
- Exposes AVR-style PCMSK/PCIFR/PCICR registers on the same 6-bit I/O bus as the PIO.

---
 rtl/atmega_pcint.sv | 133 +++++++++++++
 tb/tb_atmega_pcint.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/atmega_pcint.sv
// Pin-change interrupt controller for one 8-bit port with AVR-style PCMSK/PCIFR/PCICR registers.
// Define ATMEGA_PCINT_EDGE_SEL_EN to add the per-pin rising-edge select register PCEDGE.
module atmega_pcint #(
    parameter string                          PLATFORM          = "XILINX",
    parameter int unsigned                    BUS_ADDR_DATA_LEN = 6,
    parameter logic [BUS_ADDR_DATA_LEN-1:0]   PCMSK_ADDR        = BUS_ADDR_DATA_LEN'(3),
    parameter logic [BUS_ADDR_DATA_LEN-1:0]   PCIFR_ADDR        = BUS_ADDR_DATA_LEN'(4),
    parameter logic [BUS_ADDR_DATA_LEN-1:0]   PCICR_ADDR        = BUS_ADDR_DATA_LEN'(5),
    parameter logic [BUS_ADDR_DATA_LEN-1:0]   PCEDGE_ADDR       = BUS_ADDR_DATA_LEN'(6),
    parameter logic [7:0]                     PINMASK           = 8'hFF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
    input  logic                         wr,
    input  logic                         rd,
    input  logic [7:0]                   bus_in,
    output logic [7:0]                   bus_out,
    input  logic [7:0]                   pins,
    output logic                         int_rq,
    input  logic                         int_ack
);

    localparam int unsigned PORT_W = 8;
    localparam int unsigned ARM_W  = 2;
    localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(3);

    // Vendor tag carries no logic here; the empty block only keeps the parameter referenced.
    if (PLATFORM == "") begin : g_platform_none
    end

    logic [PORT_W-1:0] sync0;
    logic [PORT_W-1:0] sync1;
    logic [PORT_W-1:0] prev;
    logic [ARM_W-1:0]  arm_cnt;
    logic [PORT_W-1:0] pcmsk;
    logic              pcif;
    logic              pcie;
    logic [PORT_W-1:0] trig;
    logic [PORT_W-1:0] chg;
    logic              armed;
    logic              flag_set;
    logic              flag_clr;
    logic              wr_msk;
    logic              wr_ifr;
    logic              wr_icr;

`ifdef ATMEGA_PCINT_EDGE_SEL_EN
    logic [PORT_W-1:0] pcedge;
    logic              wr_edge;

    assign wr_edge = wr && (addr == PCEDGE_ADDR);
`endif

    assign wr_msk = wr && (addr == PCMSK_ADDR);
    assign wr_ifr = wr && (addr == PCIFR_ADDR);
    assign wr_icr = wr && (addr == PCICR_ADDR);
    assign armed  = (arm_cnt == ARM_MAX);

    // Per-pin trigger: any change, or rising edge only where PCEDGE selects it.
    always_comb begin
        trig = sync1 ^ prev;
`ifdef ATMEGA_PCINT_EDGE_SEL_EN
        trig = ((sync1 ^ prev) & ~pcedge) | ((sync1 & ~prev) & pcedge);
`endif
        chg      = trig & pcmsk & PINMASK;
        flag_set = armed && (chg != '0);
        flag_clr = (wr_ifr && bus_in[0]) || int_ack;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0   <= '0;
            sync1   <= '0;
            prev    <= '0;
            arm_cnt <= '0;
            pcmsk   <= '0;
            pcif    <= 1'b0;
            pcie    <= 1'b0;
`ifdef ATMEGA_PCINT_EDGE_SEL_EN
            pcedge  <= '0;
`endif
        end else begin
            sync0 <= pins;
            sync1 <= sync0;
            prev  <= sync1;
            // Detection stays off until the synchroniser has been filled from real pad levels.
            if (!armed) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end
            if (wr_msk) begin
                pcmsk <= bus_in & PINMASK;
            end
            if (wr_icr) begin
                pcie <= bus_in[0];
            end
`ifdef ATMEGA_PCINT_EDGE_SEL_EN
            if (wr_edge) begin
                pcedge <= bus_in & PINMASK;
            end
`endif
            // A new event beats a simultaneous clear so nothing is lost.
            if (flag_set) begin
                pcif <= 1'b1;
            end else if (flag_clr) begin
                pcif <= 1'b0;
            end
        end
    end

    assign int_rq = pcif & pcie;

    // Read data is zero unless this block is addressed, so it can be OR-ed onto the shared bus.
    always_comb begin
        bus_out = '0;
        if (rd) begin
            if (addr == PCMSK_ADDR) begin
                bus_out = pcmsk;
            end else if (addr == PCIFR_ADDR) begin
                bus_out = {7'b0, pcif};
            end else if (addr == PCICR_ADDR) begin
                bus_out = {7'b0, pcie};
            end else if (addr == PCEDGE_ADDR) begin
`ifdef ATMEGA_PCINT_EDGE_SEL_EN
                bus_out = pcedge;
`else
                bus_out = '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_atmega_pcint.sv
// Scoreboard bench for atmega_pcint: reads push expectations, a negedge monitor pops and compares.
module tb_atmega_pcint;

    localparam logic [5:0] A_MSK  = 6'h03;
    localparam logic [5:0] A_IFR  = 6'h04;
    localparam logic [5:0] A_ICR  = 6'h05;
    localparam logic [5:0] A_EDGE = 6'h06;
    localparam logic [5:0] A_NONE = 6'h20;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] addr;
    logic       wr;
    logic       rd;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic [7:0] pins;
    logic       int_rq;
    logic       int_ack;

    typedef struct {
        logic [7:0] bus;
        logic       irq;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    atmega_pcint dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .wr      (wr),
        .rd      (rd),
        .bus_in  (bus_in),
        .bus_out (bus_out),
        .pins    (pins),
        .int_rq  (int_rq),
        .int_ack (int_ack)
    );

    always #5 clk = ~clk;

    // Monitor: every read cycle consumes one scoreboard entry; idle cycles must drive zero.
    always @(negedge clk) begin
        exp_t e;
        if (rd) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read: bus_out=%02h with empty scoreboard", bus_out);
            end else begin
                e = sb.pop_front();
                checks++;
                if (bus_out !== e.bus) begin
                    failures++;
                    $display("FAIL %s bus_out: got %02h expected %02h", e.name, bus_out, e.bus);
                end
                checks++;
                if (int_rq !== e.irq) begin
                    failures++;
                    $display("FAIL %s int_rq: got %0b expected %0b", e.name, int_rq, e.irq);
                end
            end
        end else begin
            checks++;
            if (bus_out !== 8'h00) begin
                failures++;
                $display("FAIL idle_bus: got %02h expected 00", bus_out);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) step();
    endtask

    task automatic wr_reg(input logic [5:0] a, input logic [7:0] d);
        addr   = a;
        bus_in = d;
        wr     = 1'b1;
        step();
        wr     = 1'b0;
    endtask

    task automatic rd_chk(input logic [5:0] a, input logic [7:0] eb, input logic ei, input string nm);
        exp_t e;
        e.bus  = eb;
        e.irq  = ei;
        e.name = nm;
        sb.push_back(e);
        addr = a;
        rd   = 1'b1;
        step();
        rd   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        pins    = 8'hFF;
        wr      = 1'b0;
        rd      = 1'b0;
        int_ack = 1'b0;
        addr    = '0;
        bus_in  = '0;
        wait_n(2);
        rd_chk(A_MSK, 8'h00, 1'b0, "rst_pcmsk");
        rd_chk(A_IFR, 8'h00, 1'b0, "rst_pcifr");
        rd_chk(A_ICR, 8'h00, 1'b0, "rst_pcicr");

        // Pins held high through reset; mask opened at once, arm counter must hide the fill edge.
        rst = 1'b0;
        wr_reg(A_MSK, 8'hFF);
        wait_n(10);
        rd_chk(A_IFR, 8'h00, 1'b0, "arm_block");
        rd_chk(A_MSK, 8'hFF, 1'b0, "pcmsk_rb");

        wr_reg(A_MSK, 8'h00);
        pins = 8'h00;
        wait_n(4);
        rd_chk(A_IFR, 8'h00, 1'b0, "masked_fall");

        // Three-clock latency on pin 0.
        wr_reg(A_MSK, 8'h01);
        wr_reg(A_ICR, 8'h01);
        rd_chk(A_ICR, 8'h01, 1'b0, "pcicr_rb");
        pins = 8'h01;
        step();
        step();
        rd_chk(A_IFR, 8'h00, 1'b0, "lat_k1");
        rd_chk(A_IFR, 8'h01, 1'b1, "lat_k2");

        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        rd_chk(A_IFR, 8'h00, 1'b0, "ack_clear");

        pins = 8'h00;
        step();
        step();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        rd_chk(A_IFR, 8'h01, 1'b1, "set_wins_ack");

        pins = 8'h01;
        step();
        step();
        wr_reg(A_IFR, 8'h01);
        rd_chk(A_IFR, 8'h01, 1'b1, "set_wins_w1c");
        wr_reg(A_IFR, 8'hFE);
        rd_chk(A_IFR, 8'h01, 1'b1, "w0_keep");
        wr_reg(A_IFR, 8'h01);
        rd_chk(A_IFR, 8'h00, 1'b0, "w1c");

        // Masked toggles never flag, and unmasking afterwards is quiet.
        wr_reg(A_MSK, 8'h00);
        pins = 8'hFE;
        wait_n(5);
        rd_chk(A_IFR, 8'h00, 1'b0, "mask0_toggle");
        wr_reg(A_MSK, 8'hFF);
        wait_n(4);
        rd_chk(A_IFR, 8'h00, 1'b0, "unmask_quiet");

        pins = 8'h01;
        wait_n(3);
        rd_chk(A_IFR, 8'h01, 1'b1, "multi_pin");
        wr_reg(A_IFR, 8'h01);

        // Flag without PCIE, then late enable.
        wr_reg(A_ICR, 8'h00);
        pins = 8'h09;
        wait_n(3);
        rd_chk(A_IFR, 8'h01, 1'b0, "no_pcie");
        wr_reg(A_IFR, 8'h01);
        rd_chk(A_IFR, 8'h00, 1'b0, "clr_no_pcie");
        pins = 8'h01;
        wait_n(3);
        rd_chk(A_IFR, 8'h01, 1'b0, "reflag");
        wr_reg(A_ICR, 8'h01);
        rd_chk(A_IFR, 8'h01, 1'b1, "pcie_late");

        wr_reg(A_ICR, 8'hFF);
        rd_chk(A_ICR, 8'h01, 1'b1, "pcicr_rsvd");
        rd_chk(A_NONE, 8'h00, 1'b1, "unmapped");
        wr_reg(A_IFR, 8'h01);

`ifdef ATMEGA_PCINT_EDGE_SEL_EN
        wr_reg(A_EDGE, 8'h01);
        wr_reg(A_MSK, 8'h01);
        rd_chk(A_EDGE, 8'h01, 1'b0, "pcedge_rb");
        pins = 8'h00;
        wait_n(5);
        rd_chk(A_IFR, 8'h00, 1'b0, "edge_fall");
        pins = 8'h01;
        step();
        step();
        rd_chk(A_IFR, 8'h00, 1'b0, "edge_k1");
        rd_chk(A_IFR, 8'h01, 1'b1, "edge_rise");
`else
        wr_reg(A_EDGE, 8'h01);
        wr_reg(A_MSK, 8'h01);
        rd_chk(A_EDGE, 8'h00, 1'b0, "pcedge_unmapped");
        pins = 8'h00;
        wait_n(3);
        rd_chk(A_IFR, 8'h01, 1'b1, "any_fall");
`endif

        // Mid-operation reset clears state and re-arms.
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd_chk(A_IFR, 8'h00, 1'b0, "mid_rst_pcifr");
        rd_chk(A_MSK, 8'h00, 1'b0, "mid_rst_pcmsk");

        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            step();
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
